cfg_to_axis_ramp: RTL and testbench

Extracts one signed or unsigned field from the wide PS configuration bus and delivers it as an AXI4-Stream value. Target changes are applied through a slew-rate limiter whose step size is read from a second config word. It supersedes the fixed, always-valid config tap with three additions: a coherency filter against non-atomic PS writes, a ramp state machine, and an optional event mode with a real tready handshake. It sits between the PS config register file and the RPSPMC feedback/bias stream consumers.

---
 rtl/cfg_to_axis_ramp.sv | 114 +++++++++++
 tb/tb_cfg_to_axis_ramp.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_to_axis_ramp.sv
// Config-bus field tap with coherency filter, slew-rate limiter and AXIS out.
// The value only moves toward a target that has held steady for two samples.
module cfg_to_axis_ramp #(
  parameter int SRC_ADDR          = 0,
  parameter int SRC_BITS          = 32,
  parameter int STEP_ADDR         = 1,
  parameter int CFG_WIDTH         = 1024,
  parameter int DST_WIDTH         = 32,
  parameter int MAXIS_TDATA_WIDTH = 32,
  parameter bit SIGNED            = 1'b1,
  parameter bit CONTINUOUS        = 1'b1
) (
  input  logic                         a_clk,
  input  logic                         a_resetn,
  input  logic [CFG_WIDTH-1:0]         cfg,
  output logic [MAXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
  output logic                         M_AXIS_tvalid,
  input  logic                         M_AXIS_tready,
  output logic [DST_WIDTH-1:0]         data,
  output logic                         busy
);

  localparam int DW = DST_WIDTH;
  localparam int EW = MAXIS_TDATA_WIDTH - DST_WIDTH;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RAMP = 1'b1
  } state_t;

  state_t        r_state;
  logic [DW-1:0] r_cand;
  logic [DW-1:0] r_target;
  logic [DW-1:0] r_cur;
  logic          r_tvalid;

  logic [DW-1:0] w_raw;
  logic [DW-1:0] w_step;
  logic          w_adv;
  logic [DW:0]   w_xt;
  logic [DW:0]   w_xc;
  logic [DW:0]   w_diff;
  logic          w_neg;
  logic [DW:0]   w_mag;
  logic          w_land;
  logic [DW-1:0] w_next;
  logic          w_move;
  logic          w_chg;
  logic          w_ext;
  logic          w_unused;

  assign w_raw  = cfg[SRC_ADDR*32+SRC_BITS-1 -: DW];
  assign w_step = cfg[STEP_ADDR*32 +: DW];
  assign w_adv  = CONTINUOUS ? 1'b1 : (!r_tvalid || M_AXIS_tready);

  // One extra bit keeps target-cur exact for both signednesses
  assign w_xt   = {(SIGNED ? r_target[DW-1] : 1'b0), r_target};
  assign w_xc   = {(SIGNED ? r_cur[DW-1] : 1'b0), r_cur};
  assign w_diff = w_xt - w_xc;
  assign w_neg  = w_diff[DW];
  assign w_mag  = w_neg ? (~w_diff + 1'b1) : w_diff;

  assign w_land = (w_step == '0) || (w_mag <= {1'b0, w_step});
  assign w_next = w_land ? r_target :
                  (w_neg ? (r_cur - w_step) : (r_cur + w_step));

  assign w_move = w_adv &&
                  ((r_state == S_RAMP) || (r_target != r_cur));
  assign w_chg  = w_move && (w_next != r_cur);

  always_ff @(posedge a_clk or negedge a_resetn) begin
    if (!a_resetn) begin
      r_state  <= S_IDLE;
      r_cand   <= '0;
      r_target <= '0;
      r_cur    <= '0;
      r_tvalid <= 1'b0;
    end else begin
      r_cand <= w_raw;
      if (w_raw == r_cand) begin
        r_target <= w_raw;
      end
      if (w_move) begin
        r_cur   <= w_next;
        r_state <= w_land ? S_IDLE : S_RAMP;
      end
      if (CONTINUOUS) begin
        r_tvalid <= 1'b1;
      end else if (w_chg) begin
        r_tvalid <= 1'b1;
      end else if (r_tvalid && M_AXIS_tready) begin
        r_tvalid <= 1'b0;
      end
    end
  end

  assign w_ext = SIGNED ? r_cur[DW-1] : 1'b0;

  generate
    if (EW > 0) begin : g_ext
      assign M_AXIS_tdata = {{EW{w_ext}}, r_cur};
    end else begin : g_noext
      assign M_AXIS_tdata = r_cur;
    end
  endgenerate

  assign M_AXIS_tvalid = r_tvalid;
  assign data          = r_cur;
  assign busy          = (r_state == S_RAMP);

  // Most cfg bits belong to other consumers
  assign w_unused = ^{cfg, M_AXIS_tready, w_ext};

endmodule

// File: tb/tb_cfg_to_axis_ramp.sv
// Directed bench for cfg_to_axis_ramp: continuous, event and 16-bit variants.
// Expected beats are queued on stimulus and popped as the DUT produces them.
module tb_cfg_to_axis_ramp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [1023:0] cfg_c;
  logic [1023:0] cfg_e;
  logic [1023:0] cfg_w;
  logic          rdy_one;
  logic          tready_e;

  logic [31:0] tdata_c, data_c;
  logic        tvalid_c, busy_c;
  logic [31:0] tdata_e, data_e;
  logic        tvalid_e, busy_e;
  logic [31:0] tdata_s, tdata_u;
  logic [15:0] data_s, data_u;
  logic        tvalid_s, busy_s, tvalid_u, busy_u;

  cfg_to_axis_ramp u_c (
    .a_clk(clk), .a_resetn(rst_n), .cfg(cfg_c),
    .M_AXIS_tdata(tdata_c), .M_AXIS_tvalid(tvalid_c),
    .M_AXIS_tready(rdy_one), .data(data_c), .busy(busy_c)
  );

  cfg_to_axis_ramp #(.CONTINUOUS(1'b0)) u_e (
    .a_clk(clk), .a_resetn(rst_n), .cfg(cfg_e),
    .M_AXIS_tdata(tdata_e), .M_AXIS_tvalid(tvalid_e),
    .M_AXIS_tready(tready_e), .data(data_e), .busy(busy_e)
  );

  cfg_to_axis_ramp #(.DST_WIDTH(16)) u_s (
    .a_clk(clk), .a_resetn(rst_n), .cfg(cfg_w),
    .M_AXIS_tdata(tdata_s), .M_AXIS_tvalid(tvalid_s),
    .M_AXIS_tready(rdy_one), .data(data_s), .busy(busy_s)
  );

  cfg_to_axis_ramp #(.DST_WIDTH(16), .SIGNED(1'b0)) u_u (
    .a_clk(clk), .a_resetn(rst_n), .cfg(cfg_w),
    .M_AXIS_tdata(tdata_u), .M_AXIS_tvalid(tvalid_u),
    .M_AXIS_tready(rdy_one), .data(data_u), .busy(busy_u)
  );

  typedef struct packed {
    logic [31:0] d;
    logic        b;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    checks++;
    errors++;
    $error("FAIL %s: timeout, observed=none expected=output", tag);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d, input logic b);
    exp_t e;
    e.d = d;
    e.b = b;
    q.push_back(e);
  endtask

  task automatic set_c(input logic [31:0] v, input logic [31:0] s);
    cfg_c[31:0]  = v;
    cfg_c[63:32] = s;
  endtask

  // First change may take up to 8 cycles, later ones must be back-to-back
  task automatic drain_c(input string tag);
    logic [31:0] prev;
    int          budget;
    int          n;
    exp_t        e;
    budget = 8;
    prev   = data_c;
    while (q.size() > 0) begin
      n = 0;
      do begin
        tick();
        n++;
      end while (data_c === prev && n < budget);
      if (data_c === prev) begin
        timeout(tag);
        q.delete();
      end else begin
        e = q.pop_front();
        chk(tag, data_c, e.d);
        chk({tag, "_tdata"}, tdata_c, e.d);
        chk({tag, "_busy"}, {31'd0, busy_c}, {31'd0, e.b});
        prev   = data_c;
        budget = 1;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    exp_t        e;
    logic [31:0] first;
    int          n;

    rst_n    = 1'b0;
    cfg_c    = '0;
    cfg_e    = '0;
    cfg_w    = '0;
    rdy_one  = 1'b1;
    tready_e = 1'b0;

    tick();
    tick();
    chk("rst_data", data_c, 32'd0);
    chk("rst_tdata", tdata_c, 32'd0);
    chk("rst_tvalid", {31'd0, tvalid_c}, 32'd0);
    chk("rst_busy", {31'd0, busy_c}, 32'd0);
    chk("rst_tvalid_e", {31'd0, tvalid_e}, 32'd0);

    // Latency from cfg to cur with step 0, plus extension checks
    rst_n = 1'b1;
    set_c(32'hFFFF_FF00, 32'd0);
    cfg_w[31:0] = 32'h8000_1234;
    push(32'hFFFF_FF00, 1'b0);
    tick();
    chk("lat_e1_data", data_c, 32'd0);
    chk("lat_e1_tvalid", {31'd0, tvalid_c}, 32'd1);
    tick();
    chk("lat_e2_data", data_c, 32'd0);
    chk("lat_e2_tvalid", {31'd0, tvalid_c}, 32'd1);
    tick();
    e = q.pop_front();
    chk("lat_e3_data", data_c, e.d);
    chk("lat_e3_tdata", tdata_c, e.d);
    chk("ext_signed", tdata_s, 32'hFFFF_8000);
    chk("ext_unsigned", tdata_u, 32'h0000_8000);
    chk("ext_data", {16'd0, data_s}, 32'h0000_8000);
    chk("tvalid_e_idle", {31'd0, tvalid_e}, 32'd0);

    // Slew-limited ramps up and then down through zero
    set_c(32'd0, 32'd0);
    push(32'd0, 1'b0);
    drain_c("zero");
    set_c(32'd250, 32'd100);
    push(32'd100, 1'b1);
    push(32'd200, 1'b1);
    push(32'd250, 1'b0);
    drain_c("ramp_up");
    set_c(32'hFFFF_FFCE, 32'd100);
    push(32'd150, 1'b1);
    push(32'd50, 1'b1);
    push(32'hFFFF_FFCE, 1'b0);
    drain_c("ramp_dn");

    // A toggling field must never reach target
    cfg_c[63:32] = 32'd0;
    for (int i = 0; i < 20; i++) begin
      cfg_c[31:0] = (i % 2 == 0) ? 32'h20 : 32'h10;
      tick();
      chk("toggle_hold", data_c, 32'hFFFF_FFCE);
    end
    cfg_c[31:0] = 32'h20;
    push(32'h20, 1'b0);
    tick();
    chk("stable_e1", data_c, 32'hFFFF_FFCE);
    tick();
    chk("stable_e2", data_c, 32'hFFFF_FFCE);
    tick();
    e = q.pop_front();
    chk("stable_e3", data_c, e.d);

    // Event mode with backpressure
    cfg_e[31:0]  = 32'd30;
    cfg_e[63:32] = 32'd10;
    push(32'd10, 1'b1);
    push(32'd20, 1'b1);
    push(32'd30, 1'b0);
    n = 0;
    do begin
      tick();
      n++;
    end while (!tvalid_e && n < 8);
    if (!tvalid_e) begin
      timeout("ev_first");
      q.delete();
    end else begin
      e     = q.pop_front();
      first = e.d;
      chk("ev_first", tdata_e, e.d);
      chk("ev_first_busy", {31'd0, busy_e}, {31'd0, e.b});
      for (int i = 0; i < 5; i++) begin
        tick();
        chk("ev_stall_data", tdata_e, first);
        chk("ev_stall_valid", {31'd0, tvalid_e}, 32'd1);
      end
      tready_e = 1'b1;
      while (q.size() > 0) begin
        tick();
        e = q.pop_front();
        chk("ev_beat", tdata_e, e.d);
        chk("ev_beat_valid", {31'd0, tvalid_e}, 32'd1);
        chk("ev_beat_busy", {31'd0, busy_e}, {31'd0, e.b});
      end
      tick();
      chk("ev_drop", {31'd0, tvalid_e}, 32'd0);
      tready_e = 1'b0;
    end

    // Reset in the middle of a ramp
    set_c(32'd0, 32'd0);
    push(32'd0, 1'b0);
    drain_c("pre_rst");
    set_c(32'd1000, 32'd100);
    push(32'd100, 1'b1);
    push(32'd200, 1'b1);
    drain_c("mid_ramp");
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_data", data_c, 32'd0);
    chk("arst_tdata", tdata_c, 32'd0);
    chk("arst_tvalid", {31'd0, tvalid_c}, 32'd0);
    chk("arst_busy", {31'd0, busy_c}, 32'd0);
    tick();
    rst_n = 1'b1;
    push(32'd100, 1'b1);
    push(32'd200, 1'b1);
    drain_c("restart");
    chk("restart_tvalid", {31'd0, tvalid_c}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
